spram_be_arbiter: RTL
=====================

Name: spram_be_arbiter

Overview:
- Two-port arbiter/sequencer that shares one synchronous single-port N x 64 bit byte-enable RAM (SyncSpRamBeNx64) between two requesters.
- Grants at most one access per cycle to the RAM.
- Tracks the RAM's fixed read latency and routes each read response back to the requester that issued it.
- Sits between e.g. a DMA engine and a core-side bus adapter and the shared RAM macro.

Parameters:
- ADDR_WIDTH, 10, RAM word address width; must match the RAM instance.
- OUT_REGS, 0, must equal the RAM's OUT_REGS; read latency L = 1 + OUT_REGS cycles.

Ports:
- Clk_CI  in  1  clock
- Rst_RBI  in  1  reset; asynchronous, active-low
- Req_SI  in  2  per-port request valid; bit p = port p
- Gnt_SO  out  2  per-port grant (one-hot or zero); request accepted in the cycle Req&Gnt
- WrEn_SI  in  2  per-port write (1) / read (0)
- BEn_SI  in  2x8  per-port byte enables (writes only)
- WrData_DI  in  2x64  per-port write data
- Addr_DI  in  2xADDR_WIDTH  per-port word address
- RValid_SO  out  2  per-port read-data valid, single-cycle pulse
- RdData_DO  out  64  read data, shared by both ports, qualified by RValid_SO
- Ram_CSel_SO  out  1  RAM chip select
- Ram_WrEn_SO  out  1  RAM write enable
- Ram_BEn_SO  out  8  RAM byte enables
- Ram_WrData_DO  out  64  RAM write data
- Ram_Addr_DO  out  ADDR_WIDTH  RAM address
- Ram_RdData_DI  in  64  RAM read data

Behaviour:
- Reset values:
  - Gnt_SO=0, RValid_SO=0, Ram_CSel_SO=0.
  - RR pointer = port 0 preferred.
  - Response pipeline cleared.
  - RdData_DO passes Ram_RdData_DI through unregistered; its value is don't-care while RValid_SO=0.
- Handshake:
  - Requester holds Req and all request fields stable until it sees Gnt.
  - Gnt is combinational from Req and the RR pointer, in the same cycle (zero-wait when uncontended).
- Arbitration:
  - Exactly one request → grant it.
  - Both requesting → grant the port named by the RR pointer.
  - RR pointer updates on every grant to the non-granted port; holds when idle.
  - Guarantees at most 1 cycle of wait per port under continuous contention.
- RAM drive:
  - Ram_CSel_SO = |Gnt_SO.
  - Ram_WrEn/BEn/WrData/Addr are muxed combinationally from the granted port.
  - Mux select defaults to port 0 when idle.
  - Ram_BEn_SO is forced to 0 on reads.
- Response tracking:
  - Shift register of depth L; entry = {valid, port id}.
  - Pushed every cycle: valid=1 only for a granted read.
  - At the tail: RValid_SO[id] = valid; RdData_DO = Ram_RdData_DI.
  - Reads complete exactly L cycles after the grant cycle, in order.
  - Writes produce no response.
  - Back-to-back reads sustain 1/cycle.
- Write-then-read, same address, consecutive cycles: read returns the new data (RAM ordering). The arbiter adds no forwarding.
- Same-cycle collisions: none possible; the single-port RAM sees one op per cycle by construction.
- Reset mid-operation: in-flight responses are discarded. No RValid is issued for them after reset release.
- No response backpressure: requesters must accept RValid unconditionally.

Optional Feature:
- Macro: SPRAM_ARB_FIXED_PRIO_EN.
- Defined: port 0 always wins on contention; RR pointer logic removed; port 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Package spram_arb_pkg:
  - localparam DATA_BYTES=8, N_PORTS=2.
  - typedef port_id_t (1 bit).
  - typedef struct rsp_entry_t {logic valid; port_id_t id;}.
- Sub-module spram_arb_rr: 2-way round-robin grant with pointer register, Rst_RBI/Clk_CI.
- The macro selects fixed priority inside this sub-module.

Test Plan:
- Single port 0 write Addr=0x005, BEn=0x0F, data 0x1122334455667788, then read Addr=0x005 → Gnt same cycle; RValid_SO=01 at L cycles after the read grant; data upper 32 bits = prior contents, lower 32 bits = 0x55667788.
- Both ports read continuously for 8 cycles (port0 Addr 0x10, port1 Addr 0x20) → grants alternate 01,10,01,...; RValid alternates with the same pattern delayed by L; each port gets its own address data. Fixed-prio build: port 1 never granted.
- Back-to-back port 1 reads of Addr 0..3, OUT_REGS=1 → RValid_SO[1] high for 4 consecutive cycles starting 2 cycles after the first grant; data in address order.
- Write Addr=0x3FF BEn=0xFF with 0xDEADBEEF_CAFEF00D, read 0x3FF next cycle → 0xDEADBEEFCAFEF00D; no RValid is generated for the write.
- Assert Rst_RBI low the cycle after a read grant (OUT_REGS=1) → RValid_SO stays 0 through and after reset; next post-reset request granted to port 0 on contention.
- Idle for 5 cycles → Ram_CSel_SO=0, Gnt_SO=0, RR pointer unchanged.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared types for the single-port byte-enable RAM arbiter.
//   DATA_BYTES : bytes per RAM word (64-bit words)
//   N_PORTS    : number of requesters sharing the RAM
//   rsp_entry_t: one slot of the read-response tracking pipeline
package spram_arb_pkg;

   localparam int unsigned DATA_BYTES = 8;
   localparam int unsigned N_PORTS    = 2;

   typedef logic port_id_t;

   typedef struct packed {
      logic     valid;
      port_id_t id;
   } rsp_entry_t;

endpackage

// File: rtl/spram_arb_rr.sv
// Two-way grant generator for the shared RAM.
// Default build: round-robin. When both ports request, the port named by the
// pointer wins. After every grant the pointer moves to the port that lost.
// With SPRAM_ARB_FIXED_PRIO_EN defined, port 0 always wins, there is no
// pointer, and port 1 can starve.
// Ports:
//   Clk_CI, Rst_RBI : clock, async active-low reset
//   Req_SI[1:0]     : per-port request
//   Gnt_SO[1:0]     : per-port grant, one-hot or zero, combinational
module spram_arb_rr
   import spram_arb_pkg::*;
(
   input  logic               Clk_CI,
   input  logic               Rst_RBI,
   input  logic [N_PORTS-1:0] Req_SI,
   output logic [N_PORTS-1:0] Gnt_SO
);

`ifdef SPRAM_ARB_FIXED_PRIO_EN

   logic unused_clk_rst;
   assign unused_clk_rst = Clk_CI ^ Rst_RBI;

   always_comb begin
      Gnt_SO = '0;
      if (Req_SI[0])
         Gnt_SO = 2'b01;
      else if (Req_SI[1])
         Gnt_SO = 2'b10;
   end

`else

   port_id_t ptr_q, ptr_d;

   always_comb begin
      if (Req_SI == 2'b11)
         Gnt_SO = ptr_q ? 2'b10 : 2'b01;
      else
         Gnt_SO = Req_SI;

      // The pointer moves only on a grant, so idle cycles preserve fairness.
      ptr_d = ptr_q;
      if (Gnt_SO[0])
         ptr_d = 1'b1;
      else if (Gnt_SO[1])
         ptr_d = 1'b0;
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI)
         ptr_q <= 1'b0;
      else
         ptr_q <= ptr_d;
   end

`endif

endmodule

// File: rtl/spram_be_arbiter.sv
// Arbiter that shares one synchronous single-port N x 64 byte-enable RAM
// (SyncSpRamBeNx64) between two requesters. It grants at most one access per
// cycle and returns each read response, 1+OUT_REGS cycles later, to the port
// that issued the read.
// Build option: SPRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority
// (see spram_arb_rr).
// Ports:
//   Clk_CI, Rst_RBI            : clock, async active-low reset
//   Req_SI/Gnt_SO              : per-port request / grant; accepted on Req&Gnt
//   WrEn_SI/BEn_SI/WrData_DI/Addr_DI : per-port request fields
//   RValid_SO/RdData_DO        : per-port read-valid pulse, shared read data
//   Ram_*                      : RAM macro interface
module spram_be_arbiter
   import spram_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned OUT_REGS   = 0
) (
   input  logic                                  Clk_CI,
   input  logic                                  Rst_RBI,
   input  logic [N_PORTS-1:0]                    Req_SI,
   output logic [N_PORTS-1:0]                    Gnt_SO,
   input  logic [N_PORTS-1:0]                    WrEn_SI,
   input  logic [N_PORTS-1:0][DATA_BYTES-1:0]    BEn_SI,
   input  logic [N_PORTS-1:0][8*DATA_BYTES-1:0]  WrData_DI,
   input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]    Addr_DI,
   output logic [N_PORTS-1:0]                    RValid_SO,
   output logic [8*DATA_BYTES-1:0]               RdData_DO,
   output logic                                  Ram_CSel_SO,
   output logic                                  Ram_WrEn_SO,
   output logic [DATA_BYTES-1:0]                 Ram_BEn_SO,
   output logic [8*DATA_BYTES-1:0]               Ram_WrData_DO,
   output logic [ADDR_WIDTH-1:0]                 Ram_Addr_DO,
   input  logic [8*DATA_BYTES-1:0]               Ram_RdData_DI
);

   localparam int unsigned LAT = 1 + OUT_REGS;

   logic [N_PORTS-1:0]    gnt;
   port_id_t              sel;
   rsp_entry_t [LAT-1:0]  rsp_q, rsp_d;

   spram_arb_rr i_rr (
      .Clk_CI  (Clk_CI),
      .Rst_RBI (Rst_RBI),
      .Req_SI  (Req_SI),
      .Gnt_SO  (gnt)
   );

   assign Gnt_SO = gnt;

   // Selects port 1 only when it holds the grant. When idle, the RAM mux
   // shows port 0.
   assign sel = gnt[1];

   always_comb begin
      Ram_CSel_SO   = |gnt;
      Ram_WrEn_SO   = WrEn_SI[sel];
      Ram_BEn_SO    = WrEn_SI[sel] ? BEn_SI[sel] : '0;
      Ram_WrData_DO = WrData_DI[sel];
      Ram_Addr_DO   = Addr_DI[sel];
   end

   // Response pipeline matches the RAM read latency. An entry is pushed every
   // cycle; only a granted read carries valid.
   always_comb begin
      rsp_d          = rsp_q;
      rsp_d[0].valid = Ram_CSel_SO & ~Ram_WrEn_SO;
      rsp_d[0].id    = sel;
      for (int unsigned i = 1; i < LAT; i++)
         rsp_d[i] = rsp_q[i-1];
   end

   always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI)
         rsp_q <= '0;
      else
         rsp_q <= rsp_d;
   end

   always_comb begin
      RValid_SO                   = '0;
      RValid_SO[rsp_q[LAT-1].id]  = rsp_q[LAT-1].valid;
   end

   assign RdData_DO = Ram_RdData_DI;

endmodule
